// File: rtl/spi_slave.sv
// spi_slave: SPI responder, CPOL/CPHA modes, 1..32-bit MSB-first words, oversampled in the clk domain.
// Optional: define SPI_SLAVE_MISO_OE_EN to add spi_miso_oe and gate spi_miso with it.
module spi_slave #(
  parameter int MAX_DATA_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_sck,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  input  logic                      spi_cs,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [4:0]                bits_per_word,
  input  logic [MAX_DATA_WIDTH-1:0] tx_data,
  output logic                      tx_load,
  output logic [MAX_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic                      spi_miso_oe,
`endif
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, LAST} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
  logic sck_d, cs_d, cpol_l, cpha_l, fresh, miso_q;
  logic [4:0] bpw_l;
  logic [5:0] cnt;
  logic [MAX_DATA_WIDTH-1:0] tx_shift, rx_shift, tx_next;
  logic sck_s, mosi_s, cs_s, leading, trailing, sample, shift, cs_fall, cs_rise, last_bit, word_done;
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign leading = (sck_s != sck_d) && (sck_d == cpol_l);
  assign trailing = (sck_s != sck_d) && (sck_s == cpol_l);
  assign sample = cpha_l ? trailing : leading;
  assign shift = cpha_l ? leading : trailing;
  assign cs_fall = cs_d && !cs_s;
  assign cs_rise = !cs_d && cs_s;
  assign last_bit = cnt == {1'b0, bpw_l};
  assign word_done = cnt == {1'b0, bpw_l} + 6'd1;
  assign tx_next = tx_shift << 1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= {SYNC_STAGES{cpol}};
      mosi_sync <= '0;
      cs_sync <= '1;
      sck_d <= cpol;
      cs_d <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sck_d <= sck_s;
      cs_d <= cs_s;
    end
  end
  // fresh: the next shift edge presents the loaded MSB instead of advancing the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      miso_q <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_load <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      bpw_l <= '0;
      fresh <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          state <= ACTIVE;
          busy <= 1'b1;
          cpol_l <= cpol;
          cpha_l <= cpha;
          bpw_l <= bits_per_word;
          tx_shift <= tx_data;
          tx_load <= 1'b1;
          rx_shift <= '0;
          cnt <= '0;
          fresh <= cpha;
          if (!cpha) miso_q <= tx_data[bits_per_word];
        end
        ACTIVE: if (word_done) begin
          rx_data <= rx_shift;
          rx_valid <= 1'b1;
          rx_shift <= '0;
          cnt <= '0;
          if (cs_rise) begin
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            tx_shift <= tx_data;
            tx_load <= 1'b1;
            fresh <= 1'b1;
          end
        end else if (cs_rise && !(sample && last_bit)) begin
          state <= IDLE;
          busy <= 1'b0;
          cnt <= '0;
        end else begin
          if (cs_rise) state <= LAST;
          if (sample) begin
            rx_shift <= {rx_shift[MAX_DATA_WIDTH-2:0], mosi_s};
            cnt <= cnt + 6'd1;
          end
          if (shift) begin
            fresh <= 1'b0;
            miso_q <= fresh ? tx_shift[bpw_l] : tx_next[bpw_l];
            if (!fresh) tx_shift <= tx_next;
          end
        end
        LAST: begin
          rx_data <= rx_shift;
          rx_valid <= 1'b1;
          rx_shift <= '0;
          cnt <= '0;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPI_SLAVE_MISO_OE_EN
  assign spi_miso_oe = busy;
  assign spi_miso = busy & miso_q;
`else
  assign spi_miso = miso_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with an rx scoreboard checked by a separate monitor.
module tb_spi_slave;
  localparam int W = 32;
  localparam int H = 60;
  logic clk = 1'b0, rst_n = 1'b0, spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, cpol = 1'b0, cpha = 1'b0;
  logic [4:0] bits_per_word = 5'd7;
  logic [W-1:0] tx_data = '0;
  logic spi_miso, tx_load, rx_valid, busy;
  logic [W-1:0] rx_data;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic spi_miso_oe;
`endif
  int checks = 0, fails = 0, loads = 0;
  logic [W-1:0] exp_rx[$];
  spi_slave dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_sck(spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs(spi_cs),
    .cpol(cpol),
    .cpha(cpha),
    .bits_per_word(bits_per_word),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
`ifdef SPI_SLAVE_MISO_OE_EN
    .spi_miso_oe(spi_miso_oe),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (tx_load) loads++;
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected rx_valid: got rx_data 0x%0h, expected no strobe", rx_data);
      end else check("rx_data scoreboard", rx_data, exp_rx.pop_front());
    end
  end
  // Master side: sends n MSB-first bits of a w-bit word, collects MISO at its sample edges.
  task automatic xfer(input int w, input int n, input logic [W-1:0] mosi_w, output logic [W-1:0] miso_w);
    miso_w = '0;
    for (int i = w - 1; i >= w - n; i--) begin
      if (!cpha) begin
        spi_mosi = mosi_w[i];
        #H spi_sck = ~cpol;
        miso_w = {miso_w[W-2:0], spi_miso};
        #H spi_sck = cpol;
      end else begin
        #H spi_sck = ~cpol;
        spi_mosi = mosi_w[i];
        #H spi_sck = cpol;
        miso_w = {miso_w[W-2:0], spi_miso};
      end
    end
  endtask
  initial begin
    logic [W-1:0] m;
    int l0, n;
    repeat (3) @(negedge clk);
    check("reset spi_miso", spi_miso, 0);
    check("reset busy", busy, 0);
    check("reset rx_data", rx_data, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset tx_load", tx_load, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("reset oe", spi_miso_oe, 0);
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // mode 0, 8 bits
    tx_data = 32'hA5;
    l0 = loads;
    exp_rx.push_back(32'h3C);
    spi_cs = 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
    repeat (4) @(negedge clk);
    check("t1 oe while busy", spi_miso_oe, busy);
    check("t1 oe high", spi_miso_oe, 1);
`endif
    xfer(8, 8, 32'h3C, m);
    check("t1 miso word", m, 32'hA5);
    #H spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    check("t1 tx_load count", loads - l0, 2);
    check("t1 busy", busy, 0);
    check("t1 rx_data", rx_data, 32'h3C);
    check("t1 pending", exp_rx.size(), 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("t1 oe low", spi_miso_oe, 0);
    check("t1 miso gated", spi_miso, 0);
`endif
    // mode 3, 16 bits
    cpol = 1'b1;
    cpha = 1'b1;
    spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    bits_per_word = 5'd15;
    tx_data = 32'hBEEF;
    l0 = loads;
    exp_rx.push_back(32'h1234);
    spi_cs = 1'b0;
    xfer(16, 16, 32'h1234, m);
    check("t2 miso word", m, 32'hBEEF);
    #H spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    check("t2 tx_load count", loads - l0, 2);
    check("t2 rx_data", rx_data, 32'h1234);
    // mode 1, two 32-bit words under one cs
    cpol = 1'b0;
    cpha = 1'b1;
    spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    bits_per_word = 5'd31;
    tx_data = 32'h13579BDF;
    l0 = loads;
    exp_rx.push_back(32'hDEADBEEF);
    exp_rx.push_back(32'h01234567);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    check("t3 first tx_load", loads - l0, 1);
    tx_data = 32'hCAFEF00D;
    xfer(32, 32, 32'hDEADBEEF, m);
    check("t3 miso word 1", m, 32'h13579BDF);
    xfer(32, 32, 32'h01234567, m);
    check("t3 miso word 2", m, 32'hCAFEF00D);
    #H spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    check("t3 tx_load count", loads - l0, 3);
    check("t3 rx_data", rx_data, 32'h01234567);
    check("t3 pending", exp_rx.size(), 0);
    // mode 0, partial word aborted by cs
    cpol = 1'b0;
    cpha = 1'b0;
    bits_per_word = 5'd7;
    tx_data = 32'hFF;
    repeat (4) @(negedge clk);
    spi_cs = 1'b0;
    xfer(8, 5, 32'h96, m);
    spi_cs = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4 busy fall bound", 32'(n <= 4), 1);
    repeat (10) @(negedge clk);
    check("t4 busy", busy, 0);
    check("t4 rx_data kept", rx_data, 32'h01234567);
    // mode 2, reset mid-word then full transfer
    cpol = 1'b1;
    spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    tx_data = 32'hC3;
    spi_cs = 1'b0;
    xfer(8, 3, 32'hFF, m);
    #20 rst_n = 1'b0;
    #1;
    check("t5 reset spi_miso", spi_miso, 0);
    check("t5 reset busy", busy, 0);
    check("t5 reset rx_data", rx_data, 0);
    check("t5 reset rx_valid", rx_valid, 0);
    check("t5 reset tx_load", tx_load, 0);
    spi_cs = 1'b1;
    #9;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    l0 = loads;
    exp_rx.push_back(32'h5A);
    spi_cs = 1'b0;
    xfer(8, 8, 32'h5A, m);
    check("t5 miso word", m, 32'hC3);
    #H spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    check("t5 rx_data", rx_data, 32'h5A);
    check("t5 tx_load count", loads - l0, 2);
    check("scoreboard empty", exp_rx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) with the same mode set as the team's SPI master: CPOL/CPHA, 1..32-bit words, MSB first, single active-low chip select.
- Oversamples SCK, MOSI and CS in the system clock domain, shifts MISO out and MOSI in, and presents each completed word to the host-side register map with a one-cycle strobe.
- Used as the FPGA-side endpoint so the BeagleBone SPI master, or the on-board master looped back, can be exercised.

Parameters:
- MAX_DATA_WIDTH, 32, shift register and data port width; must be ≥ 2^5 to cover bits_per_word.
- SYNC_STAGES, 2, synchronizer flops on sck/mosi/cs (minimum 2).

Ports:
- clk  input  1  system clock; required ≥ 8× SCK frequency.
- rst_n  input  1  asynchronous active-low reset.
- spi_sck  input  1  serial clock from master.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  slave-out data.
- spi_cs  input  1  chip select, active low.
- cpol  input  1  SCK idle level.
- cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge.
- bits_per_word  input  5  word length minus 1 (0 → 1 bit, 31 → 32 bits).
- tx_data  input  MAX_DATA_WIDTH  next word to transmit, right-aligned.
- tx_load  output  1  1-cycle pulse; tx_data was latched this cycle.
- rx_data  output  MAX_DATA_WIDTH  last complete received word, right-aligned, upper bits zero.
- rx_valid  output  1  1-cycle pulse; rx_data updated this cycle.
- busy  output  1  high while a transaction is active.

Behaviour:
- Reset (rst_n low, asynchronous): spi_miso=0, rx_data=0, rx_valid=0, tx_load=0, busy=0, bit counter=0, FSM=IDLE. Synchronizer flops reset to idle values: cs=1, sck=cpol, mosi=0.
- Synchronization: sck, mosi and cs pass through SYNC_STAGES flops. Edges are detected from the last two synced sck samples.
- Edge meaning:
  - leading edge = transition away from the latched cpol level; trailing edge = transition back to it.
  - Sample edge: leading if cpha=0, trailing if cpha=1. Shift edge is the other one.
- FSM IDLE:
  - On detected cs fall: latch cpol, cpha, bits_per_word; load the shift register from tx_data (MSB at position bits_per_word); pulse tx_load; busy=1; go to ACTIVE.
  - If cpha=0, spi_miso is driven with the word MSB in the same cycle.
- FSM ACTIVE:
  - Sample edge: shift synced mosi into the receive shifter LSB; increment the bit counter.
  - Shift edge: advance the transmit shifter; spi_miso = next bit. For cpha=1 the first leading edge presents the MSB.
  - Word complete (counter reaches bits_per_word+1 on a sample edge), next cycle:
    - rx_data = received word, zero-extended; pulse rx_valid; counter=0.
    - Reload the transmit shifter from tx_data and pulse tx_load; stay ACTIVE for back-to-back words.
  - cpha=0 reload: the new MSB appears on the trailing edge that ends the word.
- cs rise detected: go to IDLE, busy=0, spi_miso holds its last value.
  - A partial word is discarded: no rx_valid, counter cleared.
  - If a final sample edge and the cs rise are detected in the same cycle, the word completes first (rx_valid pulses) and the FSM then goes IDLE.
- Config changes while busy are ignored until the next cs fall.
- SCK edges seen while in IDLE are ignored.
- Latency: the MISO update lags the real SCK edge by SYNC_STAGES+1 clk cycles. rx_valid occurs SYNC_STAGES+2 cycles after the final sample edge.

Optional Feature:
- SPI_SLAVE_MISO_OE_EN defined: adds output spi_miso_oe (1 bit).
  - Reset value 0; asserted while busy.
  - spi_miso is forced to 0 whenever spi_miso_oe=0, so a top level can tristate the pin.
- Undefined: no spi_miso_oe port; spi_miso is driven continuously as described above.

Test Plan:
- Mode 0, bits_per_word=7, tx_data=0xA5, master sends 0x3C: MISO stream 1010_0101; rx_data=0x3C with one rx_valid pulse; two tx_load pulses total (cs fall + word end).
- Mode 3 (cpol=1, cpha=1), bits_per_word=15, tx_data=0xBEEF, master sends 0x1234: MISO stream is 0xBEEF MSB first; rx_data=0x1234.
- Mode 1, 32-bit words, two words back-to-back under one cs, host updates tx_data to 0xCAFEF00D after the first tx_load:
  - rx_valid twice, rx_data=0xDEADBEEF then 0x01234567;
  - second MISO word is 0xCAFEF00D.
- Mode 0, 8-bit word with cs raised after 5 clocks: no rx_valid; rx_data keeps its previous value; busy falls within SYNC_STAGES+2 cycles.
- rst_n pulsed low mid-word in mode 2: all outputs return to reset values immediately; the next full 8-bit transfer 0x5A is received correctly.
- With SPI_SLAVE_MISO_OE_EN: spi_miso_oe=0 and spi_miso=0 while cs is high; oe rises with busy and falls at cs deassert.
